// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers, the mux and one shared consumer.
// The mux uses the slave view; the driving environment uses the master view.
interface stream_mux_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 registered valid/ready stream multiplexer.
// Channel choice is either the external sel (MODE_RR=0) or a round-robin
// scan starting just after the last granted channel (MODE_RR=1).
// A single output register gives one cycle of latency at full throughput.
module stream_mux_rr #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int MODE_RR = 1
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_rr_if.slave  bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    logic [SELW-1:0]  rr_ptr;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  chan_q;
    logic             valid_q;

    logic [SELW-1:0]  grant;
    logic             grant_valid;
    logic [SELW-1:0]  idx;
    logic             load_en;
    logic             accept;
    logic [N-1:0]     ready_w;

    // Register can take a word when empty or when its word leaves this cycle.
    assign load_en = !valid_q || bus.out_ready;
    assign accept  = !rst && load_en && grant_valid;

    // Grant selection: fixed select, or first valid channel after rr_ptr.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        if (MODE_RR != 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = SELW'((int'(rr_ptr) + k) % N);
                if (!grant_valid && bus.in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = idx;
                end
            end
        end else begin
            if ((int'(bus.sel) < N) && bus.in_valid[bus.sel]) begin
                grant_valid = 1'b1;
                grant       = bus.sel;
            end
        end
    end

    // Only the granted channel sees ready, and only when the word is taken.
    always_comb begin
        ready_w = '0;
        if (accept) begin
            ready_w[grant] = 1'b1;
        end
    end

    // Output register and round-robin pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            rr_ptr  <= SELW'(N - 1);
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= bus.in_data[grant*WIDTH +: WIDTH];
            chan_q  <= grant;
            if (MODE_RR != 0) begin
                rr_ptr <= grant;
            end
        end else if (bus.out_ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_w;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one round-robin and one fixed-select instance share
// the same stimulus and are each compared against a transaction-level model.
module tb_stream_mux_rr;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [SELW-1:0]  sel;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    // model state, index 0 = round-robin instance, 1 = fixed instance
    logic            m_valid [2];
    logic [W-1:0]    m_data  [2];
    logic [SELW-1:0] m_chan  [2];
    int              m_last = N - 1;

    always #5 clk = ~clk;

    stream_mux_rr_if #(.N(N), .WIDTH(W)) bus_rr ();
    stream_mux_rr_if #(.N(N), .WIDTH(W)) bus_fx ();

    assign bus_rr.in_data   = in_data;
    assign bus_rr.in_valid  = in_valid;
    assign bus_rr.sel       = sel;
    assign bus_rr.out_ready = out_ready;
    assign bus_fx.in_data   = in_data;
    assign bus_fx.in_valid  = in_valid;
    assign bus_fx.sel       = sel;
    assign bus_fx.out_ready = out_ready;

    stream_mux_rr #(.N(N), .WIDTH(W), .MODE_RR(1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
    stream_mux_rr #(.N(N), .WIDTH(W), .MODE_RR(0)) dut_fx (.clk(clk), .rst(rst), .bus(bus_fx));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel the specification says wins this cycle, or -1 for none.
    function automatic int model_grant(input int m);
        if (m == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (in_valid[c]) return c;
            end
            return -1;
        end
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int m);
        int g;
        if (rst) return '0;
        g = model_grant(m);
        if (g >= 0 && (!m_valid[m] || out_ready)) return N'(1) << g;
        return '0;
    endfunction

    task automatic model_update(input int m);
        int g;
        if (rst) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_chan[m]  = '0;
            if (m == 0) m_last = N - 1;
        end else begin
            g = model_grant(m);
            if (g >= 0 && (!m_valid[m] || out_ready)) begin
                m_valid[m] = 1'b1;
                m_data[m]  = in_data[g*W +: W];
                m_chan[m]  = SELW'(g);
                if (m == 0) m_last = g;
            end else if (out_ready && m_valid[m]) begin
                m_valid[m] = 1'b0;
            end
        end
    endtask

    // One clock: check ready before the edge, outputs after it.
    task automatic step(input string tag);
        #1;
        check({tag, "/rdy_rr"}, 32'(bus_rr.in_ready), 32'(exp_ready(0)));
        check({tag, "/rdy_fx"}, 32'(bus_fx.in_ready), 32'(exp_ready(1)));
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check({tag, "/vld_rr"},  32'(bus_rr.out_valid), 32'(m_valid[0]));
        check({tag, "/dat_rr"},  32'(bus_rr.out_data),  32'(m_data[0]));
        check({tag, "/chan_rr"}, 32'(bus_rr.out_chan),  32'(m_chan[0]));
        check({tag, "/vld_fx"},  32'(bus_fx.out_valid), 32'(m_valid[1]));
        check({tag, "/dat_fx"},  32'(bus_fx.out_data),  32'(m_data[1]));
        check({tag, "/chan_fx"}, 32'(bus_fx.out_chan),  32'(m_chan[1]));
        @(negedge clk);
    endtask

    initial begin
        int s4 [4];
        s4 = '{3, 0, 3, 0};

        rst       = 1'b1;
        in_valid  = '1;
        in_data   = 32'h44332211;
        sel       = 2'd0;
        out_ready = 1'b1;
        @(negedge clk);

        // reset held two cycles with every channel valid
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst/rdy_rr", 32'(bus_rr.in_ready), 0);
            check("rst/rdy_fx", 32'(bus_fx.in_ready), 0);
            step("rst");
            check("rst/vld_lit", 32'(bus_rr.out_valid), 0);
            check("rst/dat_lit", 32'(bus_rr.out_data), 0);
        end

        // fixed select of channel 2; round-robin instance starts at ch0
        rst     = 1'b0;
        sel     = 2'd2;
        in_data = 32'h11A52233;
        #1;
        check("fix/rdy_lit", 32'(bus_fx.in_ready), 32'h4);
        step("fix");
        check("fix/dat_lit",  32'(bus_fx.out_data), 32'hA5);
        check("fix/chan_lit", 32'(bus_fx.out_chan), 2);
        check("rr/chan0_lit", 32'(bus_rr.out_chan), 0);

        // fairness: continues 1,2,3,0,1
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            step("rr");
            check("rr/seq_lit", 32'(bus_rr.out_chan), 32'((i + 1) % 4));
        end

        // skip and wrap with only ch0 and ch3 requesting
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            step("wrap");
            check("wrap/seq_lit", 32'(bus_rr.out_chan), 32'(s4[i]));
        end

        // back-pressure with 3C held
        in_data  = 32'h0000003C;
        in_valid = 4'b0001;
        sel      = 2'd0;
        step("bp_load");
        check("bp/load_lit", 32'(bus_rr.out_data), 32'h3C);
        out_ready = 1'b0;
        in_valid  = '1;
        for (int i = 0; i < 3; i++) begin
            sel     = SELW'(i + 1);
            in_data = $urandom;
            #1;
            check("bp/rdy_lit_rr", 32'(bus_rr.in_ready), 0);
            check("bp/rdy_lit_fx", 32'(bus_fx.in_ready), 0);
            step("bp");
            check("bp/hold_rr", 32'(bus_rr.out_data), 32'h3C);
            check("bp/hold_fx", 32'(bus_fx.out_data), 32'h3C);
        end
        out_ready = 1'b1;
        sel       = 2'd3;
        step("bp_rel");
        check("bp/next_rr", 32'(bus_rr.out_chan), 1);
        check("bp/next_fx", 32'(bus_fx.out_chan), 3);

        // reset while stalled
        out_ready = 1'b0;
        step("stall");
        check("stall/vld_lit", 32'(bus_rr.out_valid), 1);
        rst = 1'b1;
        step("mrst");
        check("mrst/vld_lit", 32'(bus_rr.out_valid), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step("restart");
        check("restart/ch0", 32'(bus_rr.out_chan), 0);
        step("restart");
        check("restart/ch1", 32'(bus_rr.out_chan), 1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 49) == 0);
            in_valid  = N'($urandom);
            in_data   = $urandom;
            sel       = SELW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
